even_issue_stage: RTL and testbench
===================================

EVEN_ISSUE_STAGE -- requirements
Module: even_issue_stage

Interface
REQ-001 SHALL have parameter NUM_REGS, default 128: number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_W, default 4: scoreboard counter width, matching the latency field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dec_valid  input  1  decode presents an even-pipe instruction.
REQ-006 SHALL have port dec_ready  output  1  issue stage accepts the presented instruction this cycle.
REQ-007 SHALL have port dec_full_instr  input  32  raw instruction word.
REQ-008 SHALL have port dec_instr_id  input  7  decoded opcode id.
REQ-009 SHALL have port dec_unit_id  input  3  target unit: FX1=0, FX2=1, SP=2, BYTE=3.
REQ-010 SHALL have port dec_latency  input  4  result latency in cycles.
REQ-011 SHALL have port dec_reg_wr  input  1  instruction writes dec_reg_dst.
REQ-012 SHALL have port dec_reg_dst  input  7  destination register.
REQ-013 SHALL have port dec_ra_addr / dec_rb_addr / dec_rc_addr  input  7 each  source registers.
REQ-014 SHALL have port dec_ra_use / dec_rb_use / dec_rc_use  input  1 each  source actually read.
REQ-015 SHALL have port flush  input  1  discard the candidate instruction and insert a bubble.
REQ-016 SHALL have port iss_valid  output  1  issue register holds a live instruction.
REQ-017 SHALL have ports iss_full_instr(32), iss_instr_id(7), iss_unit_id(3), iss_latency(4), iss_reg_wr(1), iss_reg_dst(7), iss_ra_addr/iss_rb_addr/iss_rc_addr(7 each)  outputs  registered copies feeding the even pipe and register-file read.
REQ-018 SHALL have port stall_cycles  output  32  saturating count of hazard-stall cycles.

Function
REQ-019 SHALL keep one CNT_W-bit countdown per register; a count of 0 means the value is readable (regfile or forwarding).
REQ-020 SHALL detect a RAW hazard when any source with use=1 has a nonzero count.
REQ-021 SHALL detect a WAW hazard when dec_reg_wr=1 and the count of dec_reg_dst exceeds dec_latency.
REQ-022 SHALL drive dec_ready = !flush && !RAW && !WAW, combinationally; acceptance = dec_valid && dec_ready.
REQ-023 SHALL evaluate hazards against counts as they stand before this cycle's update.
REQ-024 On acceptance, SHALL latch all dec_* fields into the issue register and set iss_valid=1 on the next edge (1-cycle latency).
REQ-025 Without acceptance, SHALL set iss_valid=0 and iss_reg_wr=0 (bubble); other iss_* fields hold their values.
REQ-026 On acceptance with dec_reg_wr=1, SHALL load count[dec_reg_dst] = dec_latency; the load wins over that entry's decrement.
REQ-027 Every other nonzero count SHALL decrement by 1 per cycle, saturating at 0.
REQ-028 dec_latency=0 with dec_reg_wr=1 SHALL leave the destination count at 0 (no hazard window).
REQ-029 A source equal to dec_reg_dst of the same instruction SHALL be checked against the old count only.
REQ-030 flush SHALL take priority over dec_valid; scoreboard counts SHALL keep decrementing (in-flight results still complete).
REQ-031 stall_cycles SHALL increment on each cycle with dec_valid=1, flush=0, dec_ready=0, saturating at 32'hFFFFFFFF.

Reset
REQ-032 While rst=0, SHALL asynchronously clear all counts, iss_valid, iss_reg_wr, all iss_* fields and stall_cycles to 0; dec_ready then follows REQ-022 with all counts 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight scoreboard state; the first instruction after release SHALL issue without stalling.

Verification
REQ-034 Reset release, dec_valid=1, reg_wr=1, dst=5, latency=6 -> dec_ready=1; next cycle iss_valid=1, iss_reg_dst=5; count[5]=6.
REQ-035 Same as REQ-034, then a consumer with ra=5, ra_use=1 held valid -> dec_ready=0 for 6 cycles, stall_cycles=6, issue on the 7th cycle.
REQ-036 Consumer with rb=5, rb_use=0 right after the producer -> issues immediately with no stall.
REQ-037 Producer dst=9 latency=7, then next cycle writer dst=9 latency=2 -> WAW stall until count[9]<=2, then issue and reload count to 2.
REQ-038 flush=1 with dec_valid=1 -> dec_ready=0, next cycle iss_valid=0, stall_cycles unchanged, counts still decrement.
REQ-039 rst pulled low while count[3]=5 -> count cleared; after release, a reader of r3 issues in the first cycle.

Source files
------------

// File: rtl/even_issue_stage.sv
// Even-pipe issue stage: a per-register countdown scoreboard gates decode into a
// single registered issue slot. RAW and WAW hazards are checked against the counts
// from before this cycle's update.
module even_issue_stage #(
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_full_instr,
    input  logic [6:0]  dec_instr_id,
    input  logic [2:0]  dec_unit_id,
    input  logic [3:0]  dec_latency,
    input  logic        dec_reg_wr,
    input  logic [6:0]  dec_reg_dst,
    input  logic [6:0]  dec_ra_addr,
    input  logic [6:0]  dec_rb_addr,
    input  logic [6:0]  dec_rc_addr,
    input  logic        dec_ra_use,
    input  logic        dec_rb_use,
    input  logic        dec_rc_use,
    input  logic        flush,
    output logic        iss_valid,
    output logic [31:0] iss_full_instr,
    output logic [6:0]  iss_instr_id,
    output logic [2:0]  iss_unit_id,
    output logic [3:0]  iss_latency,
    output logic        iss_reg_wr,
    output logic [6:0]  iss_reg_dst,
    output logic [6:0]  iss_ra_addr,
    output logic [6:0]  iss_rb_addr,
    output logic [6:0]  iss_rc_addr,
    output logic [31:0] stall_cycles
);

    localparam int unsigned LAT_W = 4;
    localparam int unsigned CMP_W = (CNT_W > LAT_W) ? CNT_W : LAT_W;

    typedef struct packed {
        logic [31:0] full_instr;
        logic [6:0]  instr_id;
        logic [2:0]  unit_id;
        logic [3:0]  latency;
        logic        reg_wr;
        logic [6:0]  reg_dst;
        logic [6:0]  ra_addr;
        logic [6:0]  rb_addr;
        logic [6:0]  rc_addr;
    } iss_t;

    logic [CNT_W-1:0] r_cnt [NUM_REGS];
    iss_t             r_iss;
    logic             r_valid;
    logic [31:0]      r_stall;

    iss_t w_dec;
    logic w_raw;
    logic w_waw;
    logic w_ready;
    logic w_accept;

    // Hazard detection on pre-update counts; a self-referencing source sees the old count.
    always_comb begin
        w_dec = '{dec_full_instr, dec_instr_id, dec_unit_id, dec_latency, dec_reg_wr,
                  dec_reg_dst, dec_ra_addr, dec_rb_addr, dec_rc_addr};
        w_raw = (dec_ra_use && (r_cnt[dec_ra_addr] != '0)) ||
                (dec_rb_use && (r_cnt[dec_rb_addr] != '0)) ||
                (dec_rc_use && (r_cnt[dec_rc_addr] != '0));
        w_waw = dec_reg_wr && (CMP_W'(r_cnt[dec_reg_dst]) > CMP_W'(dec_latency));
        w_ready  = !flush && !w_raw && !w_waw;
        w_accept = dec_valid && w_ready;
    end

    assign dec_ready = w_ready;

    // Scoreboard: a new load beats the decrement; everything else drains toward 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_accept && dec_reg_wr && (dec_reg_dst == 7'(i))) begin
                    r_cnt[i] <= CNT_W'(dec_latency);
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Issue register: bubbles clear valid and reg_wr only, the payload holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iss   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_iss   <= w_dec;
            r_valid <= 1'b1;
        end else begin
            r_iss.reg_wr <= 1'b0;
            r_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (dec_valid && !flush && !w_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign iss_valid      = r_valid;
    assign iss_full_instr = r_iss.full_instr;
    assign iss_instr_id   = r_iss.instr_id;
    assign iss_unit_id    = r_iss.unit_id;
    assign iss_latency    = r_iss.latency;
    assign iss_reg_wr     = r_iss.reg_wr;
    assign iss_reg_dst    = r_iss.reg_dst;
    assign iss_ra_addr    = r_iss.ra_addr;
    assign iss_rb_addr    = r_iss.rb_addr;
    assign iss_rc_addr    = r_iss.rc_addr;
    assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_even_issue_stage.sv
// Directed bench for even_issue_stage: the driver pushes expected issues into a
// queue, an independent monitor pops and compares whenever iss_valid is seen.
module tb_even_issue_stage;

    typedef struct packed {
        logic [31:0] full_instr;
        logic [6:0]  instr_id;
        logic [2:0]  unit_id;
        logic [3:0]  latency;
        logic        reg_wr;
        logic [6:0]  reg_dst;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [31:0] dec_full_instr = '0;
    logic [6:0]  dec_instr_id = '0;
    logic [2:0]  dec_unit_id = '0;
    logic [3:0]  dec_latency = '0;
    logic        dec_reg_wr = 1'b0;
    logic [6:0]  dec_reg_dst = '0;
    logic [6:0]  dec_ra_addr = '0;
    logic [6:0]  dec_rb_addr = '0;
    logic [6:0]  dec_rc_addr = '0;
    logic        dec_ra_use = 1'b0;
    logic        dec_rb_use = 1'b0;
    logic        dec_rc_use = 1'b0;
    logic        flush = 1'b0;
    logic        iss_valid;
    logic [31:0] iss_full_instr;
    logic [6:0]  iss_instr_id;
    logic [2:0]  iss_unit_id;
    logic [3:0]  iss_latency;
    logic        iss_reg_wr;
    logic [6:0]  iss_reg_dst;
    logic [6:0]  iss_ra_addr;
    logic [6:0]  iss_rb_addr;
    logic [6:0]  iss_rc_addr;
    logic [31:0] stall_cycles;

    int     total = 0;
    int     bad = 0;
    instr_t exp_q[$];

    even_issue_stage #(.NUM_REGS(128), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_full_instr(dec_full_instr), .dec_instr_id(dec_instr_id),
        .dec_unit_id(dec_unit_id), .dec_latency(dec_latency),
        .dec_reg_wr(dec_reg_wr), .dec_reg_dst(dec_reg_dst),
        .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr), .dec_rc_addr(dec_rc_addr),
        .dec_ra_use(dec_ra_use), .dec_rb_use(dec_rb_use), .dec_rc_use(dec_rc_use),
        .flush(flush),
        .iss_valid(iss_valid), .iss_full_instr(iss_full_instr),
        .iss_instr_id(iss_instr_id), .iss_unit_id(iss_unit_id),
        .iss_latency(iss_latency), .iss_reg_wr(iss_reg_wr), .iss_reg_dst(iss_reg_dst),
        .iss_ra_addr(iss_ra_addr), .iss_rb_addr(iss_rb_addr), .iss_rc_addr(iss_rc_addr),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] full, input logic [2:0] unit,
                                  input logic [3:0] lat, input logic wr, input logic [6:0] dst,
                                  input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
        instr_t t;
        t = '{full, full[6:0], unit, lat, wr, dst, ra, rb, rc};
        return t;
    endfunction

    // Present one instruction; dec_ready must stay low for exactly 'stalls' cycles.
    task automatic issue_instr(input instr_t ins, input logic [2:0] uses, input int stalls);
        dec_valid      = 1'b1;
        dec_full_instr = ins.full_instr;
        dec_instr_id   = ins.instr_id;
        dec_unit_id    = ins.unit_id;
        dec_latency    = ins.latency;
        dec_reg_wr     = ins.reg_wr;
        dec_reg_dst    = ins.reg_dst;
        dec_ra_addr    = ins.ra;
        dec_rb_addr    = ins.rb;
        dec_rc_addr    = ins.rc;
        {dec_ra_use, dec_rb_use, dec_rc_use} = uses;
        for (int c = 0; c <= stalls; c++) begin
            @(negedge clk);
            chk($sformatf("dec_ready_%0h_c%0d", ins.full_instr, c), 96'(dec_ready), 96'(c == stalls));
            if (c == stalls) exp_q.push_back(ins);
            @(posedge clk);
            #1;
        end
        dec_valid = 1'b0;
        {dec_ra_use, dec_rb_use, dec_rc_use} = 3'b000;
    endtask

    // Monitor: compare every issue against the scoreboard, check bubbles hold the payload.
    initial begin
        instr_t last;
        instr_t e;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last = '0;
            end else if (iss_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got instr=%0h want=none at %0t",
                             iss_full_instr, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("iss_fields", 96'({iss_full_instr, iss_instr_id, iss_unit_id, iss_latency,
                        iss_reg_wr, iss_reg_dst, iss_ra_addr, iss_rb_addr, iss_rc_addr}), 96'(e));
                    last = e;
                end
            end else begin
                chk("bubble_reg_wr", 96'(iss_reg_wr), 96'(0));
                chk("bubble_hold", 96'({iss_full_instr, iss_reg_dst}),
                    96'({last.full_instr, last.reg_dst}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_iss_valid", 96'(iss_valid), 96'(0));
        chk("rst_iss_fields", 96'({iss_full_instr, iss_instr_id, iss_unit_id, iss_latency,
            iss_reg_wr, iss_reg_dst, iss_ra_addr, iss_rb_addr, iss_rc_addr}), 96'(0));
        chk("rst_stall", 96'(stall_cycles), 96'(0));
        chk("rst_ready", 96'(dec_ready), 96'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Producer r5 lat 6, then RAW consumer stalls 6 cycles
        issue_instr(mk(32'hA000_0001, 3'd0, 4'd6, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        issue_instr(mk(32'hA000_0002, 3'd1, 4'd1, 1'b1, 7'd6, 7'd5, 7'd0, 7'd0), 3'b100, 6);
        chk("stall_raw", 96'(stall_cycles), 96'(6));

        // Unused source does not stall
        issue_instr(mk(32'hA000_0003, 3'd2, 4'd5, 1'b1, 7'd7, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        issue_instr(mk(32'hA000_0004, 3'd3, 4'd2, 1'b0, 7'd0, 7'd6, 7'd7, 7'd0), 3'b100, 0);
        chk("stall_unused", 96'(stall_cycles), 96'(6));

        // WAW: r9 lat 7 then r9 lat 2 waits until count <= 2, reader then waits 2
        issue_instr(mk(32'hA000_0005, 3'd0, 4'd7, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        issue_instr(mk(32'hA000_0006, 3'd1, 4'd2, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0), 3'b000, 5);
        chk("stall_waw", 96'(stall_cycles), 96'(11));
        issue_instr(mk(32'hA000_0007, 3'd2, 4'd3, 1'b0, 7'd0, 7'd0, 7'd9, 7'd0), 3'b010, 2);
        chk("stall_reload", 96'(stall_cycles), 96'(13));

        // Source == destination checks the old count only
        issue_instr(mk(32'hA000_0008, 3'd3, 4'd3, 1'b1, 7'd10, 7'd10, 7'd0, 7'd0), 3'b100, 0);
        issue_instr(mk(32'hA000_0009, 3'd0, 4'd1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd10), 3'b001, 3);
        chk("stall_self", 96'(stall_cycles), 96'(16));

        // Latency 0 leaves no hazard window
        issue_instr(mk(32'hA000_000A, 3'd1, 4'd0, 1'b1, 7'd11, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        issue_instr(mk(32'hA000_000B, 3'd2, 4'd4, 1'b0, 7'd0, 7'd0, 7'd0, 7'd11), 3'b001, 0);

        // Flush blocks issue without counting stalls; counts keep draining
        issue_instr(mk(32'hA000_000C, 3'd3, 4'd4, 1'b1, 7'd12, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        dec_valid      = 1'b1;
        flush          = 1'b1;
        dec_full_instr = 32'hDEAD_0000;
        dec_reg_wr     = 1'b1;
        dec_reg_dst    = 7'd20;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("flush_ready", 96'(dec_ready), 96'(0));
            @(posedge clk);
            #1;
        end
        flush     = 1'b0;
        dec_valid = 1'b0;
        chk("flush_stall", 96'(stall_cycles), 96'(16));
        issue_instr(mk(32'hA000_000D, 3'd0, 4'd1, 1'b0, 7'd0, 7'd12, 7'd0, 7'd0), 3'b100, 2);
        chk("stall_after_flush", 96'(stall_cycles), 96'(18));

        // Reset mid-flight clears the scoreboard
        issue_instr(mk(32'hA000_000E, 3'd1, 4'd5, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0), 3'b000, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #3;
        chk("midrst_iss_valid", 96'(iss_valid), 96'(0));
        chk("midrst_iss_dst", 96'(iss_reg_dst), 96'(0));
        chk("midrst_stall", 96'(stall_cycles), 96'(0));
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        issue_instr(mk(32'hA000_000F, 3'd2, 4'd2, 1'b0, 7'd0, 7'd3, 7'd0, 7'd0), 3'b100, 0);
        chk("postrst_stall", 96'(stall_cycles), 96'(0));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 96'(exp_q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
